sonar_ping_tx: RTL



---
 rtl/sonar_ping_tx.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/sonar_ping_tx.sv
// 8-channel ultrasonic ping transmitter: steered 40 kHz square-wave bursts,
// a capture-sync pulse on the first edge, then an enforced hold-off window.

module sonar_ping_lane #(
    parameter int HALF_PERIOD = 338
) (
    input  logic        clk,
    input  logic        nRST,
    input  logic        clr,
    input  logic        run,
    input  logic [15:0] t,
    input  logic [9:0]  dly,
    input  logic [15:0] len,
    output logic        drv_p,
    output logic        drv_n
);
    localparam logic [9:0] HP_M1 = 10'(HALF_PERIOD - 1);

    logic [9:0]  hcnt_q;
    logic        ph_q;
    logic [15:0] u;
    logic        act;

    // Local time u = t - d; the counters only advance while the lane is inside its window.
    assign u     = t - {6'd0, dly};
    assign act   = run && (t >= {6'd0, dly}) && (u < len);
    assign drv_p = act && !ph_q;
    assign drv_n = act && ph_q;

    always_ff @(posedge clk) begin
        if (!nRST || clr) begin
            hcnt_q <= '0;
            ph_q   <= 1'b0;
        end else if (act) begin
            if (hcnt_q == HP_M1) begin
                hcnt_q <= '0;
                ph_q   <= !ph_q;
            end else begin
                hcnt_q <= hcnt_q + 10'd1;
            end
        end
    end
endmodule

module sonar_ping_tx #(
    parameter int HALF_PERIOD = 338,
    parameter int HOLDOFF     = 65535
) (
    input  logic       clk,
    input  logic       nRST,
    input  logic       start,
    input  logic [3:0] burstLen,
    input  logic [7:0] steer,
    output logic [7:0] tx,
    output logic [7:0] txN,
    output logic       captureStart,
    output logic       busy,
    output logic       done
);
    localparam logic [1:0]  ST_IDLE = 2'd0;
    localparam logic [1:0]  ST_RUN  = 2'd1;
    localparam logic [1:0]  ST_HOLD = 2'd2;
    localparam logic [15:0] HP16    = 16'(HALF_PERIOD);
    localparam logic [15:0] HO16    = 16'(HOLDOFF);

    logic [1:0]       state_q, state_d;
    logic [15:0]      t_q, t_d, hold_q, hold_d;
    logic [3:0]       b_q;
    logic [7:0]       s_q;
    logic [7:0]       mag;
    logic [9:0]       dmax;
    logic [7:0][9:0]  dly;
    logic [15:0]      len, t_end;
    logic [7:0]       drv_p, drv_n;
    logic             accept, run;

    assign accept = (state_q == ST_IDLE) && start && (burstLen != 4'd0);
    assign run    = (state_q == ST_RUN);

    // |S| fits 8 bits unsigned, including -128.
    assign mag   = s_q[7] ? (~s_q + 8'd1) : s_q;
    assign dmax  = 10'd7 * {2'd0, mag};
    assign len   = {11'd0, b_q, 1'b0} * HP16;
    assign t_end = {6'd0, dmax} + len - 16'd1;

    for (genvar i = 0; i < 8; i++) begin : g_lane
        localparam logic [2:0] IPOS = 3'(i);
        localparam logic [2:0] INEG = 3'(7 - i);
        logic [2:0] sel;
        assign sel    = s_q[7] ? INEG : IPOS;
        assign dly[i] = {7'd0, sel} * {2'd0, mag};

        sonar_ping_lane #(.HALF_PERIOD(HALF_PERIOD)) u_lane (
            .clk   (clk),
            .nRST  (nRST),
            .clr   (accept),
            .run   (run),
            .t     (t_q),
            .dly   (dly[i]),
            .len   (len),
            .drv_p (drv_p[i]),
            .drv_n (drv_n[i])
        );
    end

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        hold_d  = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_RUN;
                    t_d     = '0;
                end
            end
            ST_RUN: begin
                t_d = t_q + 16'd1;
                if (t_q == t_end) begin
                    state_d = ST_HOLD;
                    hold_d  = '0;
                end
            end
            ST_HOLD: begin
                if (hold_q == HO16) state_d = ST_IDLE;
                else                hold_d  = hold_q + 16'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nRST) begin
            state_q      <= ST_IDLE;
            t_q          <= '0;
            hold_q       <= '0;
            b_q          <= '0;
            s_q          <= '0;
            tx           <= '0;
            txN          <= '0;
            captureStart <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            hold_q  <= hold_d;
            if (accept) begin
                b_q <= burstLen;
                s_q <= steer;
            end
            tx           <= run ? drv_p : 8'd0;
            txN          <= run ? drv_n : 8'd0;
            captureStart <= run && (t_q == 16'd0);
            busy         <= (state_d != ST_IDLE);
            done         <= (state_q == ST_HOLD) && (state_d == ST_IDLE);
        end
    end
endmodule
